// File: rtl/sd_spi_clk_ctrl.sv
// -----------------------------------------------------------------------------
// sd_spi_clk_ctrl
//   Avalon-MM slave SPI byte engine for an SD card (SPI mode 0). Software
//   writes a byte to TXDATA and polls STATUS instead of bit-banging pins.
//   Also provides an 80-clock power-up burst with MOSI held high.
//
// Ports
//   clk, reset_n         system clock (rising edge), async active-low reset
//   chipselect, address  slave select, register index
//                        (0 TXDATA, 1 RXDATA, 2 DIVIDER, 3 STATUS)
//   write_n, writedata   active-low write strobe and 8-bit write data
//   readdata             combinational read data, zero wait states
//   sd_clk, sd_mosi      SPI clock (idle low) and data out (idle high)
//   sd_miso              SPI data in (asynchronous, synchronised here)
//   irq                  level interrupt = done & irq_en
//
// STATUS bits: [0] busy  [1] done (W1C)  [2] irq_en  [3] clk_burst
// -----------------------------------------------------------------------------
module sd_spi_clk_ctrl #(
    parameter logic [7:0] DIV_RESET = 8'd99,
    parameter int         NBITS     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       chipselect,
    input  logic [1:0] address,
    input  logic       write_n,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       sd_clk,
    output logic       sd_mosi,
    input  logic       sd_miso,
    output logic       irq
);

    localparam int         CW          = $clog2(NBITS) + 1;
    localparam logic [6:0] BURST_EDGES = 7'd80;

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_BURST} state_t;

    state_t             r_state;
    logic [7:0]         r_div;
    logic [7:0]         r_run_div;
    logic [7:0]         r_divcnt;
    logic [CW-1:0]      r_bitcnt;
    logic [6:0]         r_brstcnt;
    logic [NBITS-1:0]   r_shift;
    logic [7:0]         r_txdata;
    logic               r_sd_clk;
    logic               r_mosi;
    logic               r_done;
    logic               r_irq_en;
    logic               r_miso_s1;
    logic               r_miso_s2;
    logic [1:0]         r_smp_pipe;
    logic [1:0]         r_last_pipe;
    logic [NBITS-2:0]   r_rx;
    logic [NBITS-1:0]   r_rxdata;

    state_t             w_nxt_state;
    logic [7:0]         w_nxt_run_div;
    logic [7:0]         w_nxt_divcnt;
    logic [CW-1:0]      w_nxt_bitcnt;
    logic [6:0]         w_nxt_brstcnt;
    logic [NBITS-1:0]   w_nxt_shift;
    logic               w_nxt_sd_clk;
    logic               w_nxt_mosi;
    logic               w_done_set;

    logic w_wr, w_wr_tx, w_wr_div, w_wr_stat, w_busy, w_div_zero;
    logic w_smp, w_smp_last;

    assign w_wr       = chipselect & ~write_n;
    assign w_wr_tx    = w_wr && (address == 2'd0);
    assign w_wr_div   = w_wr && (address == 2'd2);
    assign w_wr_stat  = w_wr && (address == 2'd3);
    assign w_busy     = (r_state != S_IDLE);
    assign w_div_zero = (r_divcnt == 8'd0);

    // Rising sd_clk of a data byte: this is the instant miso is sampled.
    assign w_smp      = (r_state == S_LOW) && w_div_zero;
    assign w_smp_last = w_smp && (r_bitcnt == CW'(1));

    // ---------------- next-state / datapath ----------------
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_run_div = r_run_div;
        w_nxt_divcnt  = r_divcnt;
        w_nxt_bitcnt  = r_bitcnt;
        w_nxt_brstcnt = r_brstcnt;
        w_nxt_shift   = r_shift;
        w_nxt_sd_clk  = r_sd_clk;
        w_nxt_mosi    = r_mosi;
        w_done_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Divider is latched here so a later DIVIDER write cannot
                // disturb the transfer in flight.
                if (w_wr_tx) begin
                    w_nxt_state   = S_LOW;
                    w_nxt_shift   = writedata[NBITS-1:0];
                    w_nxt_mosi    = writedata[NBITS-1];
                    w_nxt_bitcnt  = CW'(NBITS);
                    w_nxt_divcnt  = r_div;
                    w_nxt_run_div = r_div;
                    w_nxt_sd_clk  = 1'b0;
                end else if (w_wr_stat && writedata[3]) begin
                    w_nxt_state   = S_BURST;
                    w_nxt_brstcnt = BURST_EDGES;
                    w_nxt_divcnt  = r_div;
                    w_nxt_run_div = r_div;
                    w_nxt_mosi    = 1'b1;
                    w_nxt_sd_clk  = 1'b0;
                end
            end
            S_LOW: begin
                if (w_div_zero) begin
                    w_nxt_sd_clk = 1'b1;
                    w_nxt_divcnt = r_run_div;
                    w_nxt_state  = S_HIGH;
                end else begin
                    w_nxt_divcnt = r_divcnt - 8'd1;
                end
            end
            S_HIGH: begin
                if (w_div_zero) begin
                    w_nxt_sd_clk = 1'b0;
                    w_nxt_bitcnt = r_bitcnt - CW'(1);
                    if (r_bitcnt == CW'(1)) begin
                        w_nxt_state  = S_IDLE;
                        w_nxt_mosi   = 1'b1;
                        w_nxt_divcnt = 8'd0;
                        w_done_set   = 1'b1;
                    end else begin
                        w_nxt_shift  = {r_shift[NBITS-2:0], 1'b0};
                        w_nxt_mosi   = r_shift[NBITS-2];
                        w_nxt_divcnt = r_run_div;
                        w_nxt_state  = S_LOW;
                    end
                end else begin
                    w_nxt_divcnt = r_divcnt - 8'd1;
                end
            end
            S_BURST: begin
                // Same half-period timing as a byte; count rising edges and
                // finish on the falling edge after the last one.
                if (w_div_zero) begin
                    w_nxt_divcnt = r_run_div;
                    if (!r_sd_clk) begin
                        w_nxt_sd_clk  = 1'b1;
                        w_nxt_brstcnt = r_brstcnt - 7'd1;
                    end else begin
                        w_nxt_sd_clk = 1'b0;
                        if (r_brstcnt == 7'd0) begin
                            w_nxt_state  = S_IDLE;
                            w_nxt_divcnt = 8'd0;
                            w_done_set   = 1'b1;
                        end
                    end
                end else begin
                    w_nxt_divcnt = r_divcnt - 8'd1;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // ---------------- state / register file ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_div     <= DIV_RESET;
            r_run_div <= DIV_RESET;
            r_divcnt  <= 8'd0;
            r_bitcnt  <= '0;
            r_brstcnt <= 7'd0;
            r_shift   <= '0;
            r_txdata  <= 8'h00;
            r_sd_clk  <= 1'b0;
            r_mosi    <= 1'b1;
            r_done    <= 1'b0;
            r_irq_en  <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_run_div <= w_nxt_run_div;
            r_divcnt  <= w_nxt_divcnt;
            r_bitcnt  <= w_nxt_bitcnt;
            r_brstcnt <= w_nxt_brstcnt;
            r_shift   <= w_nxt_shift;
            r_sd_clk  <= w_nxt_sd_clk;
            r_mosi    <= w_nxt_mosi;
            if (w_wr_tx && !w_busy)
                r_txdata <= writedata;
            if (w_wr_div && !w_busy)
                r_div <= writedata;
            if (w_wr_stat)
                r_irq_en <= writedata[2];
            // A completion beats a same-cycle clear.
            if (w_done_set)
                r_done <= 1'b1;
            else if (w_wr_stat && writedata[1])
                r_done <= 1'b0;
        end
    end

    // ---------------- miso capture ----------------
    // miso passes a two-flop synchroniser, so the sample strobe is delayed by
    // the same two cycles; the captured bit is the pin value at the rising
    // sd_clk edge. At DIV=0 this puts the RXDATA update one cycle after busy
    // falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_miso_s1   <= 1'b0;
            r_miso_s2   <= 1'b0;
            r_smp_pipe  <= 2'b00;
            r_last_pipe <= 2'b00;
            r_rx        <= '0;
            r_rxdata    <= '0;
        end else begin
            r_miso_s1   <= sd_miso;
            r_miso_s2   <= r_miso_s1;
            r_smp_pipe  <= {r_smp_pipe[0], w_smp};
            r_last_pipe <= {r_last_pipe[0], w_smp_last};
            if (r_smp_pipe[1])
                r_rx <= {r_rx[NBITS-3:0], r_miso_s2};
            if (r_last_pipe[1])
                r_rxdata <= {r_rx, r_miso_s2};
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        readdata = 8'h00;
        case (address)
            2'd0: readdata = r_txdata;
            2'd1: readdata = 8'(r_rxdata);
            2'd2: readdata = r_div;
            2'd3: readdata = {4'b0000, (r_state == S_BURST), r_irq_en, r_done, w_busy};
            default: readdata = 8'h00;
        endcase
    end

    assign sd_clk  = r_sd_clk;
    assign sd_mosi = r_mosi;
    assign irq     = r_done & r_irq_en;

endmodule
